// File: rtl/phase_meas_scheduler.sv
// rtl/phase_meas_scheduler.sv - round-robin period measurement engine shared across NCH phase inputs
// Define PHASE_AVG_EN to average 2**AVG_LOG2 consecutive periods per report.
module phase_meas_scheduler #(
  parameter int NCH      = 4,
  parameter int CNT_W    = 32,
  parameter int FILT_LEN = 100,
  parameter int TIMEOUT  = 400000000,
  parameter int AVG_LOG2 = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH-1:0]   phase_in,
  input  logic [NCH-1:0]   ch_en,
  input  logic             run,
  output logic             busy,
  output logic [3:0]       cur_ch,
  output logic             res_valid,
  output logic [3:0]       res_ch,
  output logic [CNT_W-1:0] res_cnt,
  output logic             res_timeout
);

  typedef enum logic [2:0] {S_IDLE, S_SELECT, S_ARM, S_MEAS, S_REPORT} state_t;
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

  state_t             state, state_nx;
  logic [NCH-1:0]     sync1, sync2;
  logic [FILT_LEN-1:0] taps;
  logic               filt_d, seen_low;
  logic [CNT_W-1:0]   cnt;
  logic [3:0]         last_ch;
  logic               sel_bit, filt, edge_p, at_tmo;
  logic               hi_hit, lo_hit, hit;
  logic [3:0]         hi_ch, lo_ch, hit_ch;
  logic               load_res, nx_timeout;
  logic [CNT_W-1:0]   nx_cnt;

`ifdef PHASE_AVG_EN
  localparam int SUM_W = CNT_W + AVG_LOG2;
  logic [SUM_W-1:0]   sum, sum_fin;
  logic [AVG_LOG2:0]  nedge;
  logic               last_edge;
  assign sum_fin   = sum + SUM_W'(cnt);
  assign last_edge = (int'(nedge) == (1 << AVG_LOG2) - 1);
`endif

  assign busy   = (state != S_IDLE);
  assign filt   = &taps;
  // seen_low keeps a pin that was already high at selection from faking an opening edge
  assign edge_p = filt & ~filt_d & seen_low;
  assign at_tmo = (cnt == TMO);

  always_comb begin
    sel_bit = 1'b0;
    for (int j = 0; j < NCH; j++)
      if (cur_ch == 4'(j)) sel_bit = sync2[j];
  end

  always_comb begin
    hi_hit = 1'b0;
    lo_hit = 1'b0;
    hi_ch  = '0;
    lo_ch  = '0;
    for (int j = NCH - 1; j >= 0; j--) begin
      if (ch_en[j] && (4'(j) > last_ch)) begin
        hi_hit = 1'b1;
        hi_ch  = 4'(j);
      end
      if (ch_en[j] && (4'(j) <= last_ch)) begin
        lo_hit = 1'b1;
        lo_ch  = 4'(j);
      end
    end
    hit    = hi_hit | lo_hit;
    hit_ch = hi_hit ? hi_ch : lo_ch;
  end

  always_comb begin
    state_nx   = state;
    load_res   = 1'b0;
    nx_timeout = 1'b0;
    nx_cnt     = '0;
    if (!run) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE:   state_nx = S_SELECT;
        S_SELECT: state_nx = hit ? S_ARM : S_IDLE;
        S_ARM: begin
          if (edge_p) begin
            state_nx = S_MEAS;
          end else if (at_tmo) begin
            state_nx   = S_REPORT;
            load_res   = 1'b1;
            nx_timeout = 1'b1;
          end
        end
        S_MEAS: begin
`ifdef PHASE_AVG_EN
          if (edge_p && last_edge) begin
            state_nx = S_REPORT;
            load_res = 1'b1;
            nx_cnt   = sum_fin[SUM_W-1:AVG_LOG2];
          end else if (!edge_p && at_tmo) begin
`else
          if (edge_p) begin
            state_nx = S_REPORT;
            load_res = 1'b1;
            nx_cnt   = cnt;
          end else if (at_tmo) begin
`endif
            state_nx   = S_REPORT;
            load_res   = 1'b1;
            nx_timeout = 1'b1;
          end
        end
        S_REPORT: state_nx = S_SELECT;
        default:  state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      sync1       <= '0;
      sync2       <= '0;
      taps        <= '0;
      filt_d      <= 1'b0;
      seen_low    <= 1'b0;
      cnt         <= '0;
      cur_ch      <= '0;
      last_ch     <= 4'(NCH - 1);
      res_valid   <= 1'b0;
      res_ch      <= '0;
      res_cnt     <= '0;
      res_timeout <= 1'b0;
`ifdef PHASE_AVG_EN
      sum         <= '0;
      nedge       <= '0;
`endif
    end else begin
      state     <= state_nx;
      sync1     <= phase_in;
      sync2     <= sync1;
      taps      <= {taps[FILT_LEN-2:0], sel_bit};
      filt_d    <= filt;
      res_valid <= load_res;
      if (!sel_bit) seen_low <= 1'b1;
      if (load_res) begin
        res_ch      <= cur_ch;
        res_cnt     <= nx_cnt;
        res_timeout <= nx_timeout;
      end
      if (run) begin
        case (state)
          S_SELECT: if (hit) begin
            cur_ch   <= hit_ch;
            taps     <= '0;
            filt_d   <= 1'b0;
            seen_low <= 1'b0;
            cnt      <= '0;
          end
          S_ARM: begin
            if (edge_p) begin
              cnt <= CNT_W'(1);
`ifdef PHASE_AVG_EN
              sum   <= '0;
              nedge <= '0;
`endif
            end else if (!at_tmo) begin
              cnt <= cnt + 1'b1;
            end
          end
          S_MEAS: begin
            if (edge_p) begin
`ifdef PHASE_AVG_EN
              // each closing edge also opens the next period
              sum   <= sum_fin;
              nedge <= nedge + 1'b1;
              cnt   <= CNT_W'(1);
`endif
            end else if (!at_tmo) begin
              cnt <= cnt + 1'b1;
            end
          end
          S_REPORT: last_ch <= cur_ch;
          default: ;
        endcase
      end
    end
  end

endmodule
